// File: rtl/clique_pkg.sv
// rtl/clique_pkg.sv - shared constants and types for the CLIQUE memory arbiter
package clique_pkg;

  localparam int MEM_DEPTH  = 1024;
  localparam int ADDR_W     = 10;
  localparam int MEM_WIDTH  = 8;
  localparam int WORD_WIDTH = 16;

  // requester roles
  localparam int REQ_SINK   = 0;
  localparam int REQ_COST   = 1;
  localparam int REQ_REWARD = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_t;

  // width of a requester index; a single requester still needs one bit
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clique_rr_pick.sv
// rtl/clique_rr_pick.sv - combinational round-robin priority picker
module clique_rr_pick
  import clique_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int PTR_W = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner,
  output logic [PTR_W-1:0] winner_idx,
  output logic             valid
);

  logic [PTR_W-1:0] cand;

  // first set request searching upward from rr_ptr, wrapping past N_REQ-1
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % N_REQ);
      if (!valid && req[cand]) begin
        winner[cand] = 1'b1;
        winner_idx   = cand;
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clique_mem_arbiter.sv
// rtl/clique_mem_arbiter.sv - round-robin word-to-byte arbiter for the CLIQUE node memory
module clique_mem_arbiter
  import clique_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*WORD_WIDTH-1:0] req_addr,
  input  logic [N_REQ*WORD_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            ack,
  output logic [WORD_WIDTH-1:0]       rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_we,
  output logic [MEM_WIDTH-1:0]        mem_wdata,
  input  logic [MEM_WIDTH-1:0]        mem_rdata
);

  localparam int PTR_W = ptr_w(N_REQ);

  arb_state_t             state_q, state_d;
  logic [N_REQ-1:0]       grant_q;
  logic [PTR_W-1:0]       rr_ptr_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [WORD_WIDTH-1:0]  wdata_q;
  logic [MEM_WIDTH-1:0]   rdata_hi_q, rdata_lo_q;

  logic [N_REQ-1:0]       pick_onehot;
  logic [PTR_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   accept;
  logic [WORD_WIDTH-1:0]  addr_arr  [N_REQ];
  logic [WORD_WIDTH-1:0]  wdata_arr [N_REQ];
  logic                   unused_addr_bits;

  clique_rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // unpack the per-requester address and data words
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i]  = req_addr[i*WORD_WIDTH +: WORD_WIDTH];
      wdata_arr[i] = req_wdata[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // only the low ADDR_W address bits reach the memory
  assign unused_addr_bits = ^req_addr;

  assign accept = (state_q == ST_IDLE) && pick_valid;

  // state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next state and byte-cycle memory outputs, decoded from state and latched fields
  always_comb begin
    state_d   = state_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    ack       = '0;
    case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_HI;
      ST_HI: begin
        mem_addr  = addr_q;
        mem_we    = we_q;
        mem_wdata = wdata_q[WORD_WIDTH-1 -: MEM_WIDTH];
        state_d   = ST_LO;
      end
      ST_LO: begin
        mem_addr  = addr_q + ADDR_W'(1);
        mem_we    = we_q;
        mem_wdata = wdata_q[MEM_WIDTH-1:0];
        state_d   = ST_ACK;
      end
      ST_ACK: begin
        ack     = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // latch the winner's request, advance the pointer, collect read bytes
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_hi_q <= '0;
      rdata_lo_q <= '0;
    end else begin
      if (accept) begin
        grant_q  <= pick_onehot;
        rr_ptr_q <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
        we_q     <= req_we[pick_idx];
        addr_q   <= addr_arr[pick_idx][ADDR_W-1:0];
        wdata_q  <= wdata_arr[pick_idx];
      end
      if (state_q == ST_LO && !we_q) rdata_hi_q <= mem_rdata;
      if (state_q == ST_ACK) begin
        grant_q <= '0;
        if (!we_q) rdata_lo_q <= mem_rdata;
      end
    end
  end

  assign grant = grant_q;
  // low byte is bypassed during the read ack so the word is whole while ack is high
  assign rdata = {rdata_hi_q, (state_q == ST_ACK && !we_q) ? mem_rdata : rdata_lo_q};

endmodule

// File: tb/tb_clique_mem_arbiter.sv
// tb/tb_clique_mem_arbiter.sv - scoreboard bench for clique_mem_arbiter
module tb_clique_mem_arbiter;

  localparam int N = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req, req_we;
  logic [N*16-1:0] req_addr, req_wdata;
  logic [N-1:0]  grant, ack;
  logic [15:0]   rdata;
  logic [9:0]    mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          mem_init;

  logic [7:0] mem [0:1023];

  typedef struct {
    int          idx;
    logic [15:0] rdata;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  clique_mem_arbiter #(.N_REQ(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .grant     (grant),
    .ack       (ack),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  // byte memory with one-cycle read latency
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h010] <= 8'hAB;
      mem[10'h011] <= 8'hCD;
      mem[10'h041] <= 8'h99;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every ack pops one expectation
  always @(negedge clock) begin
    if (!reset && !mem_init && ack != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_onehot", 32'(ack), 32'(1 << e.idx));
        check("grant_during_ack", 32'(grant), 32'(1 << e.idx));
        check("rdata", 32'(rdata), 32'(e.rdata));
      end
    end
  end

  task automatic set_req(input int idx, input logic we, input logic [15:0] a, input logic [15:0] d);
    req_we[idx] = we;
    req_addr[idx*16 +: 16] = a;
    req_wdata[idx*16 +: 16] = d;
  endtask

  task automatic push(input int idx, input logic [15:0] r);
    exp_t e;
    e.idx = idx;
    e.rdata = r;
    sb.push_back(e);
  endtask

  // waits at negedges for ack[idx]; returns number of negedges taken, or 0 on timeout
  task automatic wait_ack(input int idx, output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (ack[idx]) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) check("ack_timeout", 32'(idx), 32'hFFFF_FFFF);
  endtask

  task automatic single(input int idx, input logic we, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_r, input int exp_lat);
    int lat;
    @(negedge clock);
    set_req(idx, we, a, d);
    push(idx, exp_r);
    req[idx] = 1'b1;
    wait_ack(idx, lat);
    req[idx] = 1'b0;
    if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int lat, acks;
    bit hit;
    reset = 1'b1; mem_init = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clock);
    mem_init = 1'b0;
    @(negedge clock);
    check("rst_grant", 32'(grant), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    reset = 1'b0;

    // basic read, ack three cycles after the request is driven
    single(0, 1'b0, 16'h0010, 16'h0000, 16'hABCD, 3);
    // write, rdata holds the last read word
    single(1, 1'b1, 16'h0020, 16'h1234, 16'hABCD, 3);
    check("mem_20", 32'(mem[10'h020]), 32'h12);
    check("mem_21", 32'(mem[10'h021]), 32'h34);
    single(1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 0);
    // low byte address wraps to 0; upper address bits ignored
    single(2, 1'b1, 16'hFFFF, 16'hBEEF, 16'h1234, 0);
    check("mem_3ff", 32'(mem[10'h3FF]), 32'hBE);
    check("mem_000", 32'(mem[10'h000]), 32'hEF);

    // fairness: all three held from reset -> 0,1,2,0,1,2
    @(negedge clock);
    reset = 1'b1;
    set_req(0, 1'b0, 16'h0010, 16'h0);
    set_req(1, 1'b0, 16'h0020, 16'h0);
    set_req(2, 1'b0, 16'h03FF, 16'h0);
    req = 3'b111;
    for (int r = 0; r < 2; r++) begin
      push(0, 16'hABCD); push(1, 16'h1234); push(2, 16'hBEEF);
    end
    @(negedge clock);
    reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 40 && acks < 6; c++) begin
      @(negedge clock);
      if (ack != '0) acks++;
    end
    req = '0;
    check("fair_acks", 32'(acks), 32'd6);

    // reset right after the hi byte of a write: hi byte kept, lo byte never written
    @(negedge clock); @(negedge clock);
    set_req(0, 1'b1, 16'h0040, 16'h5678);
    req[0] = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (mem_we && mem_addr == 10'h040) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort_hi_seen", 32'(hit), 32'd1);
    reset = 1'b1;
    req = '0;
    @(negedge clock);
    check("abort_grant", 32'(grant), 0);
    check("abort_ack", 32'(ack), 0);
    check("abort_rdata", 32'(rdata), 0);
    check("abort_mem_sig", 32'({mem_addr, mem_we, mem_wdata}), 0);
    check("abort_mem_40", 32'(mem[10'h040]), 32'h56);
    check("abort_mem_41", 32'(mem[10'h041]), 32'h99);
    reset = 1'b0;

    // pointer restarts at requester 0 after reset
    @(negedge clock);
    set_req(0, 1'b0, 16'h0010, 16'h0);
    set_req(1, 1'b0, 16'h0020, 16'h0);
    push(0, 16'hABCD); push(1, 16'h1234);
    req = 3'b011;
    wait_ack(0, lat); req[0] = 1'b0;
    wait_ack(1, lat); req[1] = 1'b0;

    // back-to-back: re-asserted req0 yields to pending req1
    @(negedge clock);
    req[0] = 1'b1;
    push(0, 16'hABCD);
    @(negedge clock);
    req[1] = 1'b1;
    push(1, 16'h1234);
    wait_ack(0, lat); req[0] = 1'b0;
    @(negedge clock);
    req[0] = 1'b1;
    push(0, 16'hABCD);
    wait_ack(1, lat); req[1] = 1'b0;
    wait_ack(0, lat); req[0] = 1'b0;

    repeat (4) @(negedge clock);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
